// File: rtl/pattern_test_ctrl.sv
// Sequencer for the 32-bit incrementing-pattern link test: re-inits the checker,
// streams 1,5,9,... to the link TX, counts RX words/errors and reports the result.
module pattern_test_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_usr,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] word_count,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic        chk_err,
  output logic        chk_rst,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] rx_cnt,
  output logic [31:0] err_cnt
);

  localparam int unsigned     WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SEND  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]    r_len, r_tx_cnt, r_tx_data, r_rx_cnt, r_err_cnt;
  logic [WDW-1:0] r_wd;
  logic           r_rx_valid_d, r_timeout;
  logic           r_tx_valid, r_chk_rst, r_busy, r_done, r_pass;

  logic [31:0]    w_tx_cnt_nxt, w_tx_data_nxt, w_rx_cnt_nxt, w_err_cnt_nxt;
  logic [WDW-1:0] w_wd_nxt;
  logic           w_timeout_nxt, w_pass_calc;
  logic           w_tx_valid_nxt, w_chk_rst_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic           w_hs, w_last_hs, w_counting, w_drain_ok, w_wd_exp, w_accept;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  assign w_hs       = r_tx_valid & tx_ready;
  assign w_last_hs  = w_hs & ((r_tx_cnt + 32'd1) == r_len);
  assign w_counting = (r_state == S_SEND) | (r_state == S_DRAIN);
  // the cycle after the last rx_valid still carries that word's error flag
  assign w_drain_ok = (r_rx_cnt >= r_len) & ~r_rx_valid_d;
  assign w_wd_exp   = ~rx_valid & (r_wd == WD_LAST);
  assign w_accept   = (r_state == S_IDLE) & start & ~abort;

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_INIT;
        else          w_state_nxt = S_IDLE;
      end
      S_INIT: begin
        if (abort)               w_state_nxt = S_IDLE;
        else if (r_len == 32'd0) w_state_nxt = S_DONE;
        else                     w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (abort)          w_state_nxt = S_IDLE;
        else if (w_last_hs) w_state_nxt = S_DRAIN;
        else                w_state_nxt = S_SEND;
      end
      S_DRAIN: begin
        if (abort)                     w_state_nxt = S_IDLE;
        else if (w_drain_ok | w_wd_exp) w_state_nxt = S_DONE;
        else                           w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_cnt_nxt  = r_tx_cnt;
    w_tx_data_nxt = r_tx_data;
    w_rx_cnt_nxt  = r_rx_cnt;
    w_err_cnt_nxt = r_err_cnt;
    w_wd_nxt      = r_wd;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_INIT: begin
        w_tx_cnt_nxt  = 32'd0;
        w_tx_data_nxt = 32'h0000_0001;
        w_rx_cnt_nxt  = 32'd0;
        w_err_cnt_nxt = 32'd0;
        w_wd_nxt      = '0;
        w_timeout_nxt = 1'b0;
      end
      S_SEND, S_DRAIN: begin
        if (rx_valid) w_rx_cnt_nxt = sat_inc(r_rx_cnt);
        else          w_rx_cnt_nxt = r_rx_cnt;
        if (r_rx_valid_d && chk_err) w_err_cnt_nxt = sat_inc(r_err_cnt);
        else                         w_err_cnt_nxt = r_err_cnt;
        if (w_hs) begin
          w_tx_data_nxt = r_tx_data + 32'd4;
          w_tx_cnt_nxt  = r_tx_cnt + 32'd1;
        end else begin
          w_tx_data_nxt = r_tx_data;
          w_tx_cnt_nxt  = r_tx_cnt;
        end
        if (r_state == S_DRAIN) begin
          if (rx_valid)              w_wd_nxt = '0;
          else if (r_wd != WD_LAST)  w_wd_nxt = r_wd + WDW'(1);
          else                       w_wd_nxt = r_wd;
          if (!abort && !w_drain_ok && w_wd_exp) w_timeout_nxt = 1'b1;
          else                                   w_timeout_nxt = r_timeout;
        end else begin
          w_wd_nxt      = r_wd;
          w_timeout_nxt = r_timeout;
        end
      end
      default: begin
        w_wd_nxt = r_wd;
      end
    endcase
  end

  assign w_pass_calc = (w_err_cnt_nxt == 32'd0) & (w_rx_cnt_nxt == r_len) & ~w_timeout_nxt;

  always_comb begin
    w_tx_valid_nxt = (w_state_nxt == S_SEND);
    w_chk_rst_nxt  = (w_state_nxt == S_INIT);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    if (w_state_nxt == S_DONE) begin
      w_pass_nxt = w_pass_calc;
    end else if ((r_state != S_IDLE) && (abort || (r_state == S_INIT))) begin
      w_pass_nxt = 1'b0;
    end else begin
      w_pass_nxt = r_pass;
    end
  end

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= 32'd0;
      r_tx_cnt     <= 32'd0;
      r_tx_data    <= 32'h0000_0001;
      r_rx_cnt     <= 32'd0;
      r_err_cnt    <= 32'd0;
      r_wd         <= '0;
      r_timeout    <= 1'b0;
      r_rx_valid_d <= 1'b0;
    end else begin
      r_len        <= w_accept ? word_count : r_len;
      r_tx_cnt     <= w_tx_cnt_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_wd         <= w_wd_nxt;
      r_timeout    <= w_timeout_nxt;
      r_rx_valid_d <= w_counting & rx_valid;
    end
  end

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_chk_rst  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_tx_valid <= w_tx_valid_nxt;
      r_chk_rst  <= w_chk_rst_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign chk_rst  = r_chk_rst;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign timeout  = r_timeout;
  assign rx_cnt   = r_rx_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_pattern_test_ctrl.sv
// Scoreboard bench for pattern_test_ctrl: stimulus pushes expected TX words and
// results; a negedge monitor (which also models the 3-cycle loopback) pops and compares.
module tb_pattern_test_ctrl;

  localparam int unsigned TMO = 16;

  logic        clk_usr = 1'b0;
  logic        rst_n, start, abort, tx_ready, rx_valid, chk_err;
  logic [31:0] word_count;
  logic [31:0] tx_data, rx_cnt, err_cnt;
  logic        tx_valid, chk_rst, busy, done, pass, timeout;

  pattern_test_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_usr(clk_usr), .rst_n(rst_n), .start(start), .abort(abort),
    .word_count(word_count), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .chk_err(chk_err),
    .chk_rst(chk_rst), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .rx_cnt(rx_cnt), .err_cnt(err_cnt)
  );

  always #5 clk_usr = ~clk_usr;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [31:0] rx;
    logic [31:0] err;
    int          gap;
  } res_t;

  logic [31:0] tx_q[$];
  res_t        res_q[$];
  res_t        res_now;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  hist = 4'd0;
  logic [3:0]  rdy_pat = 4'b1111;
  int          rx_limit = 0, rx_sent = 0, err_left = 0, ncyc = 0, last_rx = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor + loopback: compare handshakes/results, then drive rx_valid/chk_err
  initial begin
    rx_valid = 1'b0;
    chk_err  = 1'b0;
    forever begin
      @(negedge clk_usr);
      ncyc++;
      if (stall_prev) begin
        chk1("tx_hold_valid", tx_valid, 1'b1);
        chk("tx_hold_data", tx_data, stall_data);
      end
      stall_prev = tx_valid && !tx_ready && !abort && rst_n;
      stall_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected: got %0h expected no handshake", tx_data);
        end else begin
          chk("tx_word", tx_data, tx_q.pop_front());
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          res_now = res_q.pop_front();
          chk1("res_pass", pass, res_now.pass);
          chk1("res_timeout", timeout, res_now.tmo);
          chk("res_rx_cnt", rx_cnt, res_now.rx);
          chk("res_err_cnt", err_cnt, res_now.err);
          if (res_now.gap >= 0) chk("timeout_gap", 32'(ncyc - last_rx), 32'(res_now.gap));
        end
      end
      chk_err = rx_valid && (err_left > 0);
      if (chk_err) err_left--;
      hist = {hist[2:0], tx_valid && tx_ready};
      rx_valid = hist[3] && (rx_sent < rx_limit);
      if (rx_valid) begin
        rx_sent++;
        last_rx = ncyc;
      end
    end
  end

  task automatic cfg_lb(input int lim, input int errs);
    rx_limit = lim;
    rx_sent  = 0;
    err_left = errs;
  endtask

  task automatic push_tx(input int n);
    logic [31:0] v;
    v = 32'd1;
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(v);
      v = v + 32'd4;
    end
  endtask

  task automatic push_res(input logic p, input logic t, input logic [31:0] rx, input logic [31:0] er, input int gap);
    res_t r;
    r.pass = p; r.tmo = t; r.rx = rx; r.err = er; r.gap = gap;
    res_q.push_back(r);
  endtask

  task automatic do_start(input logic [31:0] wc);
    @(posedge clk_usr); #1;
    start = 1'b1;
    word_count = wc;
    @(posedge clk_usr); #1;
    start = 1'b0;
    chk1("chk_rst_t1", chk_rst, 1'b1);
    chk1("busy_t1", busy, 1'b1);
    chk1("tx_valid_t1", tx_valid, 1'b0);
    @(posedge clk_usr); #1;
    if (wc != 32'd0) begin
      chk1("tx_valid_t2", tx_valid, 1'b1);
      chk("tx_data_t2", tx_data, 32'd1);
    end else begin
      chk1("done_t2_len0", done, 1'b1);
      chk1("pass_t2_len0", pass, 1'b1);
    end
  endtask

  task automatic wait_idle(input int bound);
    bit idle_seen;
    idle_seen = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk_usr); #1;
      tx_ready = rdy_pat[i % 4];
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!idle_seen) begin
      n_err++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", bound);
    end
    tx_ready = 1'b1;
    repeat (5) @(posedge clk_usr);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_tx_data", tx_data, 32'h0000_0001);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk1("rst_chk_rst", chk_rst, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_pass", pass, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk("rst_rx_cnt", rx_cnt, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1; word_count = 32'd0;
    repeat (3) @(posedge clk_usr);
    #1;
    rst_n = 1'b1;
    check_reset_vals();

    // loopback 8 words, with a start pulse while busy that must be ignored
    cfg_lb(1000, 0);
    push_tx(8);
    push_res(1'b1, 1'b0, 32'd8, 32'd0, -1);
    do_start(32'd8);
    @(posedge clk_usr); #1;
    start = 1'b1; word_count = 32'd2;
    @(posedge clk_usr); #1;
    start = 1'b0;
    wait_idle(200);

    // two checker errors
    cfg_lb(1000, 2);
    push_tx(8);
    push_res(1'b0, 1'b0, 32'd8, 32'd2, -1);
    do_start(32'd8);
    wait_idle(200);

    // only 3 of 4 words return: watchdog fires 16 idle cycles after last rx
    cfg_lb(3, 0);
    push_tx(4);
    push_res(1'b0, 1'b1, 32'd3, 32'd0, 17);
    do_start(32'd4);
    wait_idle(200);

    // tx_ready toggling 1,0,0,1
    cfg_lb(1000, 0);
    rdy_pat = 4'b1001;
    tx_ready = 1'b1;
    push_tx(5);
    push_res(1'b1, 1'b0, 32'd5, 32'd0, -1);
    do_start(32'd5);
    wait_idle(200);
    rdy_pat = 4'b1111;

    // abort in SEND after two handshakes, then restart
    cfg_lb(1000, 0);
    push_tx(2);
    do_start(32'd8);
    @(posedge clk_usr); #1;
    @(posedge clk_usr); #1;
    abort = 1'b1; tx_ready = 1'b0;
    @(posedge clk_usr); #1;
    abort = 1'b0; tx_ready = 1'b1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_tx_valid", tx_valid, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_pass", pass, 1'b0);
    repeat (6) @(posedge clk_usr);
    #1;
    chk("idle_ignores_rx", rx_cnt, 32'd0);
    chk1("idle_busy", busy, 1'b0);
    cfg_lb(1000, 0);
    push_tx(3);
    push_res(1'b1, 1'b0, 32'd3, 32'd0, -1);
    do_start(32'd3);
    wait_idle(200);

    // zero-length test
    push_res(1'b1, 1'b0, 32'd0, 32'd0, -1);
    do_start(32'd0);
    wait_idle(20);

    // asynchronous reset in DRAIN
    cfg_lb(2, 0);
    push_tx(4);
    do_start(32'd4);
    repeat (7) @(posedge clk_usr);
    #1;
    chk("drain_rx_cnt", rx_cnt, 32'd2);
    chk1("drain_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk_usr); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk_usr);
    #1;

    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_test_ctrl.md
# pattern_test_ctrl

Sequencer for the 32-bit incrementing-pattern link test. It re-initialises the pattern checker, generates the test stream (1, 5, 9, … step 4) towards the link TX with a valid/ready handshake, and monitors the checker's registered error flag on the RX side. It reports words received, accumulated errors, timeout and a one-cycle completion result, and sits between the host register block and the link loopback datapath.

## Interface
- TIMEOUT, 1024: idle cycles without rx_valid in DRAIN before the test is declared timed out (≥2).
- clk_usr  in  1  user clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a test. Ignored unless the block is in IDLE.
- abort  in  1  forces a return to IDLE from any state.
- word_count  in  32  words to send. Latched on an accepted start.
- tx_data  out  32  pattern word to the link TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  TX accepts the word when tx_valid & tx_ready.
- rx_valid  in  1  same strobe that drives the checker's rx-valid input.
- chk_err  in  1  checker error flag, registered one cycle after its rx_valid.
- chk_rst  out  1  active-high checker re-init (checker expects 1 next).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- pass  out  1  result of the last completed test.
- timeout  out  1  last test ended by watchdog.
- rx_cnt  out  32  words received in the current or last test.
- err_cnt  out  32  checker errors in the current or last test (saturating).

## Operation
- States: IDLE, INIT, SEND, DRAIN, DONE.
- IDLE:
  - All strobes are low.
  - rx_valid and chk_err are ignored; counters and result outputs hold.
  - start → INIT.
- INIT (1 cycle):
  - chk_rst=1.
  - Latch word_count into len.
  - Clear rx_cnt, err_cnt, tx_cnt, timeout, pass, and the watchdog.
  - Load tx_data=32'h0000_0001.
  - len==0 → DONE; else → SEND.
- SEND:
  - tx_valid=1.
  - On handshake: tx_data += 4 (wraps mod 2^32), tx_cnt += 1.
  - The handshake that makes tx_cnt==len → DRAIN; tx_valid drops in the next cycle.
- DRAIN:
  - tx_valid=0.
  - Exit when rx_cnt ≥ len and the error pipeline is empty (no rx_valid in the previous cycle) → DONE.
  - Watchdog increments each cycle without rx_valid and clears on rx_valid.
  - Watchdog reaching TIMEOUT → timeout=1, → DONE.
- DONE (1 cycle):
  - done=1.
  - pass = (err_cnt==0) & (rx_cnt==len) & ~timeout.
  - → IDLE.
- Counting, active in SEND and DRAIN:
  - rx_valid → rx_cnt += 1.
  - rx_valid_d (rx_valid delayed one cycle) & chk_err → err_cnt += 1, saturating at 32'hFFFF_FFFF.
  - rx_cnt also saturates at 32'hFFFF_FFFF.
  - Excess words (rx_cnt > len) are counted and cause pass=0.
- abort in INIT/SEND/DRAIN/DONE:
  - Next state is IDLE; done does not pulse.
  - pass=0 and tx_valid=0 from the next cycle.
  - Counters hold their partial values.
  - abort takes priority over every other transition.
- start in the same cycle as abort while in IDLE: abort wins and start is dropped.

## Timing
- Reset values:
  - State IDLE.
  - tx_data=32'h0000_0001.
  - tx_valid=0, chk_rst=0, busy=0, done=0, pass=0, timeout=0.
  - rx_cnt=0, err_cnt=0.
- start sampled at cycle t → chk_rst=1 and busy=1 at t+1; tx_valid=1 from t+2 (len>0).
- tx_data and tx_valid are registered and stay stable while tx_valid & ~tx_ready.
- An error flagged by chk_err at cycle c is counted at c+1. DRAIN waits one cycle after the last rx_valid so the final error is included.
- len==0: done pulses at t+2 with pass=1.
- All outputs are registered; there is no combinational input→output path.

## Test plan
- Loopback, tx_ready=1, word_count=8, rx = TX delayed 3 cycles, chk_err=0 → tx_data sequence 1,5,…,29; done pulse; pass=1, rx_cnt=8, err_cnt=0.
- Same setup with chk_err=1 for 2 cycles, each following an rx_valid → err_cnt=2, pass=0, done pulse.
- word_count=4, only 3 rx words returned, TIMEOUT=16 → timeout=1 sixteen idle cycles after the last rx, pass=0, rx_cnt=3.
- tx_ready toggling 1,0,0,1 over word_count=5 → tx_data held during stalls; exactly 5 handshakes with values 1,5,9,13,17.
- abort in SEND after 2 handshakes → IDLE next cycle, tx_valid=0, busy=0, no done, pass=0; a subsequent start asserts chk_rst and restarts at tx_data=1.
- start while busy → ignored. word_count=0 → done at t+2, pass=1. rst_n low mid-DRAIN → all outputs at reset values immediately.
